// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU: one outstanding transaction, data-first with a starvation guard.
// Optional response timeout is built when MEM_ARB_TIMEOUT_EN is defined.
module riscv_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_rd_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_accept_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_data_o,
  output logic        inst_error_o,
  input  logic        data_rd_i,
  input  logic [3:0]  data_wr_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_accept_o,
  output logic        data_valid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_error_o,
  output logic        mem_rd_o,
  output logic [3:0]  mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_accept_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_error_i
);

  if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("riscv_mem_arbiter: STARVE_LIMIT must be 1..15");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("riscv_mem_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic        tag_q, tag_d;
  logic        inst_valid_q, inst_valid_d;
  logic        inst_error_q, inst_error_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic        data_valid_q, data_valid_d;
  logic        data_error_q, data_error_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic data_req;
  logic inst_win;
  logic data_win;
  logic req_active;
  logic timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_MAX = 16'(TIMEOUT_CYCLES);
  logic [15:0] tmo_q, tmo_d;

  // An ack arriving on the expiry cycle still completes normally.
  assign timeout_hit = (tmo_q == TMO_MAX) &&
                       ((state_q == ST_REQ) || (state_q == ST_RESP && !mem_ack_i));

  always_comb begin
    tmo_d = tmo_q;
    if (inst_win || data_win) begin
      tmo_d = '0;
    end else if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Data normally wins; inst overrides once the data streak hits the limit.
  assign data_req   = data_rd_i || (data_wr_i != 4'd0);
  assign inst_win   = !rst_i && (state_q == ST_IDLE) && inst_rd_i &&
                      (!data_req || (starve_q == STARVE_MAX));
  assign data_win   = !rst_i && (state_q == ST_IDLE) && data_req && !inst_win;
  assign req_active = (state_q == ST_REQ) && !timeout_hit;

  assign inst_accept_o = inst_win;
  assign data_accept_o = data_win;
  assign mem_rd_o      = req_active && (strb_q == 4'd0);
  assign mem_wr_o      = req_active ? strb_q : 4'd0;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign inst_valid_o  = inst_valid_q;
  assign inst_error_o  = inst_error_q;
  assign inst_data_o   = inst_data_q;
  assign data_valid_o  = data_valid_q;
  assign data_error_o  = data_error_q;
  assign data_rdata_o  = data_rdata_q;

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    tag_d        = tag_q;
    inst_valid_d = 1'b0;
    inst_error_d = inst_error_q;
    inst_data_d  = inst_data_q;
    data_valid_d = 1'b0;
    data_error_d = data_error_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (inst_win) begin
          state_d  = ST_REQ;
          starve_d = 4'd0;
          addr_d   = inst_addr_i;
          wdata_d  = 32'd0;
          strb_d   = 4'd0;
          tag_d    = 1'b0;
        end else if (data_win) begin
          state_d  = ST_REQ;
          starve_d = inst_rd_i ? (starve_q + 4'd1) : 4'd0;
          addr_d   = data_addr_i;
          wdata_d  = data_wdata_i;
          strb_d   = data_wr_i;  // nonzero strobes make a combined rd+wr a write
          tag_d    = 1'b1;
        end
      end
      ST_REQ: begin
        if (mem_accept_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_ack_i) begin
          state_d = ST_IDLE;
          if (tag_q) begin
            data_valid_d = 1'b1;
            data_error_d = mem_error_i;
            data_rdata_d = (strb_q != 4'd0) ? 32'd0 : mem_rdata_i;
          end else begin
            inst_valid_d = 1'b1;
            inst_error_d = mem_error_i;
            inst_data_d  = mem_rdata_i;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout_hit) begin
      state_d = ST_IDLE;
      if (tag_q) begin
        data_valid_d = 1'b1;
        data_error_d = 1'b1;
        data_rdata_d = 32'd0;
      end else begin
        inst_valid_d = 1'b1;
        inst_error_d = 1'b1;
        inst_data_d  = 32'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      starve_q     <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      strb_q       <= 4'd0;
      tag_q        <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_error_q <= 1'b0;
      inst_data_q  <= 32'd0;
      data_valid_q <= 1'b0;
      data_error_q <= 1'b0;
      data_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      tag_q        <= tag_d;
      inst_valid_q <= inst_valid_d;
      inst_error_q <= inst_error_d;
      inst_data_q  <= inst_data_d;
      data_valid_q <= data_valid_d;
      data_error_q <= data_error_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: bus model, response scoreboard and per-feature scenario tasks.
module tb_riscv_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        inst_rd_i = 1'b0;
  logic [31:0] inst_addr_i = 32'd0;
  logic        inst_accept_o, inst_valid_o, inst_error_o;
  logic [31:0] inst_data_o;
  logic        data_rd_i = 1'b0;
  logic [3:0]  data_wr_i = 4'd0;
  logic [31:0] data_addr_i = 32'd0;
  logic [31:0] data_wdata_i = 32'd0;
  logic        data_accept_o, data_valid_o, data_error_o;
  logic [31:0] data_rdata_o;
  logic        mem_rd_o;
  logic [3:0]  mem_wr_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_accept_i = 1'b0;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        mem_error_i = 1'b0;

  riscv_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .inst_rd_i(inst_rd_i), .inst_addr_i(inst_addr_i), .inst_accept_o(inst_accept_o),
    .inst_valid_o(inst_valid_o), .inst_data_o(inst_data_o), .inst_error_o(inst_error_o),
    .data_rd_i(data_rd_i), .data_wr_i(data_wr_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_accept_o(data_accept_o), .data_valid_o(data_valid_o),
    .data_rdata_o(data_rdata_o), .data_error_o(data_error_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .mem_error_i(mem_error_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic src; logic [31:0] data; logic err; } exp_t;
  exp_t exp_q[$];
  logic grant_log[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  int bus_acc_dly = 0, bus_ack_dly = 0, bus_ph = 0, bus_cnt = 0;
  bit bus_err = 1'b0, bus_silent = 1'b0, stray_ack = 1'b0;

  logic [138:0] all_outs;
  assign all_outs = {inst_accept_o, inst_valid_o, inst_data_o, inst_error_o,
                     data_accept_o, data_valid_o, data_rdata_o, data_error_o,
                     mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o};

  function automatic logic [31:0] bus_data(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;  // 0x100 reads back 0xDEADBEEF
  endfunction

  // Bus slave: accepts after bus_acc_dly cycles, acks bus_ack_dly cycles later.
  always begin
    @(posedge clk); #1;
    mem_accept_i = 1'b0; mem_ack_i = 1'b0; mem_error_i = 1'b0; mem_rdata_i = 32'd0;
    if (rst_i) begin
      bus_ph = 0;
    end else begin
      if (bus_ph == 0 && stray_ack) begin
        mem_ack_i = 1'b1; mem_error_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
      end
      if (bus_ph == 0 && (mem_rd_o || mem_wr_o != 4'd0)) begin
        bus_ph = 1; bus_cnt = bus_acc_dly;
      end
      if (bus_ph == 1) begin
        if (bus_cnt == 0) begin
          mem_accept_i = 1'b1; bus_ph = 2; bus_cnt = bus_ack_dly;
        end else bus_cnt = bus_cnt - 1;
      end else if (bus_ph == 2 && !bus_silent) begin
        if (bus_cnt == 0) begin
          mem_ack_i = 1'b1; mem_error_i = bus_err; mem_rdata_i = bus_data(mem_addr_o); bus_ph = 0;
        end else bus_cnt = bus_cnt - 1;
      end
    end
  end

  // Scoreboard: push on accept, pop and compare on each valid pulse.
  always begin
    @(negedge clk); #2;
    if (rst_i) begin
      exp_q.delete();
    end else begin
      checks++;
      if (inst_accept_o && data_accept_o) begin
        failures++; $display("FAIL single_accept: both accepts high");
      end
      if (inst_accept_o) begin
        exp_q.push_back('{1'b0, bus_silent ? 32'd0 : bus_data(inst_addr_i), bus_silent | bus_err});
        grant_log.push_back(1'b0);
      end
      if (data_accept_o) begin
        exp_q.push_back('{1'b1, (bus_silent || data_wr_i != 4'd0) ? 32'd0 : bus_data(data_addr_i),
                          bus_silent | bus_err});
        grant_log.push_back(1'b1);
      end
      if (inst_valid_o || data_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL sb_unexpected: inst_valid=%0b data_valid=%0b with no pending txn", inst_valid_o, data_valid_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (inst_valid_o && data_valid_o) begin
            failures++; $display("FAIL sb_both_valid: both valid pulses high");
          end else if (data_valid_o !== mon_e.src) begin
            failures++; $display("FAIL sb_source: got data_valid=%0b, expected src=%0b", data_valid_o, mon_e.src);
          end else if (mon_e.src && {data_rdata_o, data_error_o} !== {mon_e.data, mon_e.err}) begin
            failures++; $display("FAIL sb_data_resp: got %h/err%0b, expected %h/err%0b", data_rdata_o, data_error_o, mon_e.data, mon_e.err);
          end else if (!mon_e.src && {inst_data_o, inst_error_o} !== {mon_e.data, mon_e.err}) begin
            failures++; $display("FAIL sb_inst_resp: got %h/err%0b, expected %h/err%0b", inst_data_o, inst_error_o, mon_e.data, mon_e.err);
          end else begin
            $display("txn src=%0b data=%h err=%0b ok", mon_e.src, mon_e.data, mon_e.err);
          end
        end
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge clk); #3;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    #1; checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h, expected 0", all_outs); end
    inst_rd_i = 1'b1; data_rd_i = 1'b1; #1; checks++;
    if ({inst_accept_o, data_accept_o} !== 2'b00) begin
      failures++; $display("FAIL reset_accept: got %b, expected 00", {inst_accept_o, data_accept_o});
    end
    @(negedge clk); inst_rd_i = 1'b0; data_rd_i = 1'b0; rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    @(negedge clk); inst_rd_i = 1'b1; inst_addr_i = 32'h100; #1; checks++;
    if (inst_accept_o !== 1'b1) begin failures++; $display("FAIL read_accept_T: got %b, expected 1", inst_accept_o); end
    @(negedge clk); checks++;
    if ({inst_accept_o, mem_rd_o, mem_wr_o, mem_addr_o} !== {1'b0, 1'b1, 4'd0, 32'h100}) begin
      failures++; $display("FAIL read_req_T1: acc=%b rd=%b wr=%h addr=%h, expected 0 1 0 00000100", inst_accept_o, mem_rd_o, mem_wr_o, mem_addr_o);
    end
    inst_rd_i = 1'b0;
    @(negedge clk); checks++;
    if (mem_rd_o !== 1'b0) begin failures++; $display("FAIL read_req_drop_T2: mem_rd=%b, expected 0", mem_rd_o); end
    @(negedge clk); checks++;
    if ({inst_valid_o, inst_data_o, inst_error_o} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      failures++; $display("FAIL read_valid_T3: v=%b d=%h e=%b, expected 1 deadbeef 0", inst_valid_o, inst_data_o, inst_error_o);
    end
    @(negedge clk); checks++;
    if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL read_pulse_T4: v=%b, expected 0", inst_valid_o); end
    wait_drain();
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    inst_rd_i = 1'b1; inst_addr_i = 32'h300;
    data_wr_i = 4'hF; data_addr_i = 32'h200; data_wdata_i = 32'h12345678; #1; checks++;
    if ({data_accept_o, inst_accept_o} !== 2'b10) begin
      failures++; $display("FAIL simul_grant: data/inst accept=%b, expected 10", {data_accept_o, inst_accept_o});
    end
    @(negedge clk); checks++;
    if ({mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o} !== {1'b0, 4'hF, 32'h200, 32'h12345678}) begin
      failures++; $display("FAIL simul_write_req: rd=%b wr=%h addr=%h wdata=%h", mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o);
    end
    data_wr_i = 4'd0;
    @(negedge clk);
    @(negedge clk); #1; checks++;
    if ({data_valid_o, inst_accept_o} !== 2'b11) begin
      failures++; $display("FAIL simul_overlap: data_valid/inst_accept=%b, expected 11", {data_valid_o, inst_accept_o});
    end
    @(negedge clk); checks++;
    if ({mem_rd_o, mem_addr_o} !== {1'b1, 32'h300}) begin
      failures++; $display("FAIL simul_inst_req: rd=%b addr=%h, expected 1 00000300", mem_rd_o, mem_addr_o);
    end
    inst_rd_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_rd_and_wr();
    @(negedge clk); data_rd_i = 1'b1; data_wr_i = 4'b0011; data_addr_i = 32'h240; data_wdata_i = 32'hA5A55A5A;
    @(negedge clk); checks++;
    if ({mem_rd_o, mem_wr_o} !== {1'b0, 4'b0011}) begin
      failures++; $display("FAIL rdwr_is_write: rd=%b wr=%h, expected 0 3", mem_rd_o, mem_wr_o);
    end
    data_rd_i = 1'b0; data_wr_i = 4'd0;
    wait_drain();
  endtask

  task automatic test_starvation();
    logic exp_g;
    grant_log.delete();
    @(negedge clk); inst_rd_i = 1'b1; inst_addr_i = 32'h500; data_rd_i = 1'b1; data_addr_i = 32'h400;
    for (int i = 0; i < 80; i++) begin
      #3; if (grant_log.size() >= 10) break;
      @(negedge clk);
    end
    @(negedge clk); inst_rd_i = 1'b0; data_rd_i = 1'b0;
    checks++;
    if (grant_log.size() < 10) begin
      failures++; $display("FAIL starve_count: got %0d grants, expected 10", grant_log.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        exp_g = (i % 5 == 4) ? 1'b0 : 1'b1;
        checks++;
        if (grant_log[i] !== exp_g) begin
          failures++; $display("FAIL starve_seq[%0d]: got src %0b, expected %0b", i, grant_log[i], exp_g);
        end
      end
    end
    wait_drain();
  endtask

  task automatic test_bus_error();
    int n;
    bus_err = 1'b1;
    @(negedge clk); data_rd_i = 1'b1; data_addr_i = 32'h600;
    @(negedge clk); data_rd_i = 1'b0;
    n = 0;
    while (!data_valid_o && n < 20) begin @(negedge clk); n++; end
    checks++;
    if ({data_valid_o, data_error_o} !== 2'b11) begin
      failures++; $display("FAIL err_pulse: valid/error=%b, expected 11", {data_valid_o, data_error_o});
    end
    @(negedge clk); checks++;
    if (data_valid_o !== 1'b0) begin failures++; $display("FAIL err_one_cycle: valid=%b, expected 0", data_valid_o); end
    bus_err = 1'b0;
    inst_rd_i = 1'b1; inst_addr_i = 32'h700;
    @(negedge clk); inst_rd_i = 1'b0;
    n = 0;
    while (!inst_valid_o && n < 20) begin @(negedge clk); n++; end
    checks++;
    if ({inst_valid_o, inst_error_o, inst_data_o} !== {1'b1, 1'b0, bus_data(32'h700)}) begin
      failures++; $display("FAIL err_recover: v=%b e=%b d=%h, expected 1 0 %h", inst_valid_o, inst_error_o, inst_data_o, bus_data(32'h700));
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bus_ack_dly = 3;
    @(negedge clk); data_rd_i = 1'b1; data_addr_i = 32'h800;
    @(negedge clk); data_rd_i = 1'b0;
    @(negedge clk); rst_i = 1'b1;
    @(negedge clk); #1; checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL rst_mid_outputs: got %h, expected 0", all_outs); end
    @(negedge clk); rst_i = 1'b0; stray_ack = 1'b1; bus_ack_dly = 0;
    @(negedge clk); stray_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({inst_valid_o, data_valid_o} !== 2'b00) begin
        failures++; $display("FAIL rst_mid_no_valid[%0d]: inst/data valid=%b, expected 00", i, {inst_valid_o, data_valid_o});
      end
      @(negedge clk);
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus_silent = 1'b1;
    @(negedge clk); inst_rd_i = 1'b1; inst_addr_i = 32'h900;
    @(negedge clk); inst_rd_i = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL timeout_early: valid=%b at T+9, expected 0", inst_valid_o); end
    @(negedge clk); checks++;
    if ({inst_valid_o, inst_error_o, inst_data_o} !== {1'b1, 1'b1, 32'd0}) begin
      failures++; $display("FAIL timeout_pulse: v=%b e=%b d=%h, expected 1 1 0", inst_valid_o, inst_error_o, inst_data_o);
    end
    bus_silent = 1'b0;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_rd_and_wr();
    test_starvation();
    test_bus_error();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL final_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
